// File: rtl/div_ctrl.sv
// Run-time clock divider controller: 50%-duty clkout plus tick enable, glitch-free
// start/stop and handshaked period reprogramming. Optional status ports: DIV_CTRL_STATUS_EN.
module div_ctrl #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned DEF_HALF = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clkout,
  output logic             tick,
  output logic             busy
`ifdef DIV_CTRL_STATUS_EN
  , output logic [15:0]      per_cnt
  , output logic [CNT_W-1:0] cnt_out
`endif
);

  // state | meaning
  // IDLE  | stopped, clkout held low, counter cleared, cfg writes half directly
  // RUN   | counting with half_q, cfg accepted into pend_q
  // PEND  | counting with half_q, pend_q applied at the next falling toggle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_HALF_C = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             acc_ok;
  logic             wrap;
  logic             pend_now;
  logic [CNT_W-1:0] new_pend;

  assign accept = cfg_valid && ready_q;
  assign acc_ok = accept && (cfg_half != '0);
  assign wrap   = (cnt_q == (half_q - ONE_C));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    pend_d   = pend_q;
    clkout_d = clkout_q;
    tick_d   = 1'b0;
    err_d    = accept && (cfg_half == '0);
    pend_now = 1'b0;
    new_pend = pend_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        clkout_d = 1'b0;
        if (acc_ok) half_d = cfg_half;
        if (en) state_d = ST_RUN;
      end
      ST_RUN, ST_PEND: begin
        // A config accepted this cycle counts as pending for the stop/apply rules below.
        pend_now = (state_q == ST_PEND) || acc_ok;
        if (acc_ok) begin
          new_pend = cfg_half;
          pend_d   = cfg_half;
          state_d  = ST_PEND;
        end
        if (!en && !clkout_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (pend_now) half_d = new_pend;
        end else if (wrap) begin
          cnt_d    = '0;
          clkout_d = ~clkout_q;
          tick_d   = ~clkout_q;
          if (clkout_q) begin
            if (pend_now) half_d = new_pend;
            state_d = en ? ST_RUN : ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        clkout_d = 1'b0;
      end
    endcase

    ready_d = (state_d != ST_PEND);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      half_q   <= DEF_HALF_C;
      pend_q   <= '0;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      pend_q   <= pend_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign clkout    = clkout_q;
  assign tick      = tick_q;
  assign busy      = busy_q;

`ifdef DIV_CTRL_STATUS_EN
  logic [15:0] per_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_q <= '0;
    end else if (clkout_q && !clkout_d) begin
      per_q <= per_q + 16'd1;
    end
  end

  assign per_cnt = per_q;
  assign cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed scenarios plus randomized traffic
// compared against a half-period-countdown reference model.
module tb_div_ctrl;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DEF_HALF = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clkout;
  logic             tick;
  logic             busy;
`ifdef DIV_CTRL_STATUS_EN
  logic [15:0]      per_cnt;
  logic [CNT_W-1:0] cnt_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clkout    (clkout),
    .tick      (tick),
    .busy      (busy)
`ifdef DIV_CTRL_STATUS_EN
    , .per_cnt (per_cnt)
    , .cnt_out (cnt_out)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [4:0] dut_vec;
  assign dut_vec = {clkout, tick, cfg_ready, cfg_err, busy};

  // Reference model: a running flag, output level, and cycles left in the current half.
  bit          m_run, m_level, m_tick, m_err, m_haspend;
  int          m_left, m_half, m_pend;
  logic [15:0] m_per;

  task automatic model_reset();
    m_run = 0; m_level = 0; m_tick = 0; m_err = 0; m_haspend = 0;
    m_left = 0; m_half = DEF_HALF; m_pend = 0; m_per = 16'd0;
  endtask

  function automatic logic [4:0] m_out();
    return {m_level, m_tick, !(m_run && m_haspend), m_err, m_run};
  endfunction

  task automatic model_step();
    bit acc, ok;
    acc    = cfg_valid && !(m_run && m_haspend);
    ok     = acc && (cfg_half != 0);
    m_err  = acc && (cfg_half == 0);
    m_tick = 0;
    if (!m_run) begin
      if (ok) m_half = int'(cfg_half);
      if (en) begin
        m_run  = 1;
        m_left = m_half;
      end
    end else begin
      if (ok) begin
        m_haspend = 1;
        m_pend    = int'(cfg_half);
      end
      if (!en && !m_level) begin
        m_run = 0;
        if (m_haspend) begin m_half = m_pend; m_haspend = 0; end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_level = !m_level;
          if (m_level) m_tick = 1;
          else begin
            m_per = m_per + 16'd1;
            if (m_haspend) begin m_half = m_pend; m_haspend = 0; end
            if (!en) m_run = 0;
          end
          m_left = m_half;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic wait_rise(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cycle();
      if (clkout && tick) ok = 1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cycle();
      if (!busy) ok = 1;
    end
  endtask

  task automatic load_idle_half(input int h);
    cfg_valid = 1; cfg_half = CNT_W'(h);
    cycle();
    cfg_valid = 0;
  endtask

  task automatic test_reset();
    rst = 0; en = 0; cfg_valid = 0; cfg_half = '0;
    model_reset();
    #12;
    n_checks++;
    if (dut_vec !== 5'b00100) begin
      n_fail++;
      $display("FAIL reset_values: {clkout,tick,ready,err,busy} got %b want 00100", dut_vec);
    end
    @(posedge clk); #4; rst = 1;
  endtask

  task automatic test_basic_run();
    bit c[1:40]; bit t[1:40]; int nt; bit ok;
    en = 1;
    cycle();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: busy got %b want 1", busy); end
    nt = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      c[i] = clkout; t[i] = tick;
      if (i <= 35) nt += int'(tick);
      n_checks++;
      if (dut_vec !== m_out()) begin
        n_fail++;
        $display("FAIL basic_model cyc %0d: got %b want %b", i, dut_vec, m_out());
      end
    end
    n_checks++;
    if ({c[3], c[4], t[4]} !== 3'b011) begin
      n_fail++; $display("FAIL basic_first_rise: c3,c4,t4 got %b%b%b want 011", c[3], c[4], t[4]);
    end
    n_checks++;
    if ({c[4], c[5], c[6], c[7], c[8], c[9], c[10], c[11], c[12]} !== 9'b111100001) begin
      n_fail++; $display("FAIL basic_duty: clkout cyc4..12 not 111100001");
    end
    n_checks++;
    if (nt !== 4) begin n_fail++; $display("FAIL basic_ticks: got %0d want 4", nt); end
    en = 0;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_stop_timeout: busy got 1 want 0"); end
  endtask

  task automatic test_idle_cfg();
    bit c[1:16]; bit rdy_all; int nr; bit ok;
    load_idle_half(2);
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cfg_ready: got %b want 1", cfg_ready); end
    en = 1;
    cycle();
    rdy_all = 1; nr = 0;
    for (int i = 1; i <= 16; i++) begin
      cycle();
      c[i] = clkout;
      rdy_all &= cfg_ready;
      nr += int'(tick);
      n_checks++;
      if (dut_vec !== m_out()) begin
        n_fail++;
        $display("FAIL idle_cfg_model cyc %0d: got %b want %b", i, dut_vec, m_out());
      end
    end
    n_checks++;
    if ({c[1], c[2], c[3], c[4], c[5], c[6]} !== 6'b011001) begin
      n_fail++; $display("FAIL idle_cfg_period: clkout cyc1..6 not 011001");
    end
    n_checks++;
    if (nr !== 4 || !rdy_all) begin
      n_fail++; $display("FAIL idle_cfg_ticks_ready: ticks %0d ready_all %b want 4 1", nr, rdy_all);
    end
    en = 0;
    wait_idle(ok);
  endtask

  task automatic test_reprogram();
    logic [9:0] cv, rv; bit ok;
    load_idle_half(4);
    en = 1;
    cycle();
    wait_rise(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reprog_rise_timeout: clkout got 0 want 1"); end
    cfg_valid = 1; cfg_half = CNT_W'(3);
    for (int i = 1; i <= 10; i++) begin
      cycle();
      cfg_valid = 0;
      cv[10-i] = clkout; rv[10-i] = cfg_ready;
      n_checks++;
      if (dut_vec !== m_out()) begin
        n_fail++;
        $display("FAIL reprog_model cyc %0d: got %b want %b", i, dut_vec, m_out());
      end
    end
    n_checks++;
    if (cv !== 10'b1110001110) begin
      n_fail++; $display("FAIL reprog_clkout: got %b want 1110001110", cv);
    end
    n_checks++;
    if (rv !== 10'b0001111111) begin
      n_fail++; $display("FAIL reprog_ready: got %b want 0001111111", rv);
    end
  endtask

  task automatic test_cfg_zero();
    bit c[1:12]; bit ok;
    wait_rise(ok);
    cfg_valid = 1; cfg_half = '0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      cfg_valid = 0;
      c[i] = clkout;
      if (i == 1) begin
        n_checks++;
        if ({cfg_err, cfg_ready, busy} !== 3'b111) begin
          n_fail++; $display("FAIL zero_err_pulse: err,ready,busy got %b want 111", {cfg_err, cfg_ready, busy});
        end
      end
      if (i == 2) begin
        n_checks++;
        if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL zero_err_width: err got %b want 0", cfg_err); end
      end
      n_checks++;
      if (dut_vec !== m_out()) begin
        n_fail++;
        $display("FAIL zero_model cyc %0d: got %b want %b", i, dut_vec, m_out());
      end
    end
    n_checks++;
    if ({c[2], c[3], c[5], c[6], c[11], c[12]} !== 6'b100101) begin
      n_fail++; $display("FAIL zero_period: period changed after rejected cfg");
    end
  endtask

  task automatic test_stop();
    logic [3:0] cv; logic [1:0] bv; int nt, nc; bit ok;
    en = 0;
    wait_idle(ok);
    load_idle_half(4);
    en = 1;
    cycle();
    wait_rise(ok);
    en = 0;
    nt = 0; nc = 0;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (i <= 4) cv[4-i] = clkout;
      if (i == 3) bv[1] = busy;
      if (i == 4) bv[0] = busy;
      if (i >= 4) nc += int'(clkout);
      nt += int'(tick);
      n_checks++;
      if (dut_vec !== m_out()) begin
        n_fail++;
        $display("FAIL stop_model cyc %0d: got %b want %b", i, dut_vec, m_out());
      end
    end
    n_checks++;
    if (cv !== 4'b1110 || bv !== 2'b10) begin
      n_fail++; $display("FAIL stop_tail: clkout %b busy %b want 1110 10", cv, bv);
    end
    n_checks++;
    if (nt !== 0 || nc !== 0) begin
      n_fail++; $display("FAIL stop_quiet: ticks %0d highs %0d want 0 0", nt, nc);
    end
  endtask

  task automatic test_async_reset();
    bit c[0:10]; bit t[0:10]; bit ok;
    en = 1;
    cycle();
    wait_rise(ok);
    cycle();
    #2; rst = 0;
    #1;
    n_checks++;
    if (dut_vec !== 5'b00100) begin
      n_fail++; $display("FAIL async_reset: got %b want 00100", dut_vec);
    end
`ifdef DIV_CTRL_STATUS_EN
    n_checks++;
    if (per_cnt !== 16'd0) begin n_fail++; $display("FAIL async_per_cnt: got %0d want 0", per_cnt); end
`endif
    model_reset();
    rst = 1;
    for (int i = 0; i <= 10; i++) begin
      cycle();
      c[i] = clkout; t[i] = tick;
      n_checks++;
      if (dut_vec !== m_out()) begin
        n_fail++;
        $display("FAIL async_model cyc %0d: got %b want %b", i, dut_vec, m_out());
      end
    end
    n_checks++;
    if ({c[3], c[4], t[4]} !== 3'b011) begin
      n_fail++; $display("FAIL async_first_rise: c3,c4,t4 got %b%b%b want 011", c[3], c[4], t[4]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_half  = CNT_W'($urandom_range(0, 5));
      cycle();
      n_checks++;
      if (dut_vec !== m_out()) begin
        n_fail++;
        $display("FAIL random_model cyc %0d: got %b want %b", i, dut_vec, m_out());
      end
`ifdef DIV_CTRL_STATUS_EN
      n_checks++;
      if (per_cnt !== m_per) begin
        n_fail++; $display("FAIL random_per_cnt cyc %0d: got %0d want %0d", i, per_cnt, m_per);
      end
`endif
    end
    cfg_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_idle_cfg();
    test_reprogram();
    test_cfg_zero();
    test_stop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
